xgriscv_mem_arbiter: RTL
========================

Name: xgriscv_mem_arbiter

Overview:
Shares one single-ported memory between the IF-stage instruction fetch port and the MEM-stage load/store port of the xgriscv pipeline. It arbitrates between the two requesters and allows one outstanding transaction at a time. It also handles byte lanes: store replication and byte enables from swhb, load extraction and extension from lwhb and lunsigned. It raises misalignment errors and drives per-port grants, which the pipeline uses as stall conditions.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, data width (fixed 32; byte-lane logic assumes 4 lanes)
STARVE_LIMIT, 4, consecutive data grants with i_req pending before instruction is forced; 0 = data always wins

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
i_req  in  1  fetch request, held with i_addr until i_gnt
i_addr  in  ADDR_WIDTH  fetch address (word aligned; [1:0] ignored)
i_gnt  out  1  fetch accepted this cycle
i_rvalid  out  1  fetch data valid, 1-cycle pulse
i_rdata  out  DATA_WIDTH  fetched instruction
d_req  in  1  data request, held with all d_* fields until d_gnt
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_WIDTH  byte address
d_wdata  in  DATA_WIDTH  store data, low-aligned
d_swhb  in  2  store size: 11 word, 10 half, 01 byte, 00 treated as word
d_lwhb  in  2  load size, same encoding
d_lunsigned  in  1  zero-extend load
d_gnt  out  1  data request accepted (or rejected as misaligned) this cycle
d_rvalid  out  1  load data / store ack, 1-cycle pulse
d_rdata  out  DATA_WIDTH  extracted, extended load data (0 for stores)
d_misalign  out  1  1-cycle pulse with d_gnt when the access is misaligned
mem_req  out  1  memory request
mem_we  out  1  memory write
mem_addr  out  ADDR_WIDTH  word address ([1:0] forced 0)
mem_be  out  4  byte enables (1111 for reads)
mem_wdata  out  DATA_WIDTH  lane-replicated store data
mem_gnt  in  1  memory accepts mem_req this cycle
mem_rvalid  in  1  response (read data or write ack), any latency >= 1
mem_rdata  in  DATA_WIDTH  read data

Behaviour:
- States: IDLE, WAIT_I, WAIT_D. Reset (reset low, async) -> IDLE, starve_cnt = 0; all outputs 0.
- IDLE, arbitration is combinational:
  - If only one request is pending, that request wins.
  - If both are pending, data wins unless STARVE_LIMIT != 0 and starve_cnt == STARVE_LIMIT, in which case instruction wins.
- The winner's fields drive mem_* with mem_req = 1.
- On mem_gnt: the matching i_gnt/d_gnt = 1 in the same cycle; next state is WAIT_I or WAIT_D. Without mem_gnt, stay in IDLE with no grant; arbitration is recomputed each cycle.
- Registered at data grant: addr[1:0], lwhb, lunsigned, we.
- WAIT_x: mem_req = 0, no grants. On mem_rvalid, pulse i_rvalid or d_rvalid with data, then go to IDLE. A new issue is possible the following cycle, so the minimum request-to-rvalid latency is 2 cycles.
- mem_rvalid in IDLE (e.g. after reset mid-transaction) is ignored; nothing is forwarded.
- starve_cnt:
  - +1 (saturating at STARVE_LIMIT) on each data grant while i_req = 1.
  - Cleared on instruction grant, or in any cycle where i_req = 0.
- Misalignment:
  - Word access with addr[1:0] != 0, or half access with addr[0] != 0.
  - Only the access's own size (swhb for stores, lwhb for loads) is checked.
  - If data wins in IDLE and the access is misaligned: mem_req = 0, d_gnt = 1, d_misalign = 1, no d_rvalid, stay in IDLE. This counts as a data grant for starve_cnt.
- Store lanes:
  - Byte: wdata = {4{b}}, be = 0001 << addr[1:0].
  - Half: wdata = {2{h}}, be = 0011 << (2*addr[1]).
  - Word: be = 1111.
- Load extract: shift mem_rdata right by 8*addr[1:0], take 8/16/32 bits, sign-extend unless lunsigned. Store ack gives d_rdata = 0.
- i_rdata = mem_rdata unmodified. rdata outputs are 0 when the matching rvalid is 0.

Decomposition:
- Shared xgriscv_defines.v gets the state encodings and the size encodings LWHB_W/H/B (11/10/01), shared with the controller's lwhb/swhb.
- One sub-module, xgriscv_lane_align, holds the combinational store replication/byte-enable generation and load extract/extend; it is unit-testable on its own.

Test Plan:
- Load word, 1-cycle memory: d_req, d_addr = 0x100, lwhb = 11; mem_rdata = 0xDEADBEEF -> d_gnt at cycle 0, d_rvalid at cycle 2, d_rdata = 0xDEADBEEF, mem_be = 1111.
- Signed byte load: d_addr = 0x103, lwhb = 01, lunsigned = 0; mem_rdata = 0x80112233 -> d_rdata = 0xFFFFFF80. Same with lunsigned = 1 -> 0x00000080.
- Half store: d_addr = 0x202, swhb = 10, wdata = 0x0000ABCD -> mem_wdata = 0xABCDABCD, mem_be = 1100, mem_addr = 0x200, d_rvalid on ack.
- Contention with STARVE_LIMIT = 2, both requests held continuously -> grant order D, D, I, D, D, I.
- Misaligned word load at 0x102 -> d_gnt = 1 and d_misalign = 1 in the same cycle, mem_req = 0, no d_rvalid.
- Reset low during WAIT_D, then mem_rvalid arrives after reset is released -> state IDLE, no d_rvalid, and the next i_req is served normally.

Source files
------------

// File: rtl/xgriscv_mem_arbiter_pkg.sv
// Shared encodings for the xgriscv memory arbiter: FSM states, access size
// codes (shared with the controller's lwhb/swhb) and the latched data-access context.
package xgriscv_mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT_I = 2'd1,
      ST_WAIT_D = 2'd2
   } arb_state_e;

   localparam logic [1:0] LWHB_W = 2'b11;
   localparam logic [1:0] LWHB_H = 2'b10;
   localparam logic [1:0] LWHB_B = 2'b01;

   // Data-access fields captured at grant, needed when the response returns
   typedef struct packed {
      logic [1:0] off;
      logic [1:0] lwhb;
      logic       lunsigned;
      logic       we;
   } dctx_t;

   // Size code 00 behaves as a word access
   function automatic logic [1:0] eff_size(input logic [1:0] size);
      return (size == 2'b00) ? LWHB_W : size;
   endfunction

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      logic [1:0] s;
      s = eff_size(size);
      return ((s == LWHB_W) && (off != 2'b00)) || ((s == LWHB_H) && off[0]);
   endfunction

endpackage

// File: rtl/xgriscv_lane_align.sv
// Byte-lane steering: store data replication / byte enables, and load
// extraction with sign or zero extension.
//   st_off_i/st_size_i/st_wdata_i -> st_wdata_o, st_be_o
//   ld_off_i/ld_size_i/ld_unsigned_i/ld_rdata_i -> ld_data_o
module xgriscv_lane_align
   import xgriscv_mem_arbiter_pkg::*;
(
   input  logic [1:0]  st_off_i,
   input  logic [1:0]  st_size_i,
   input  logic [31:0] st_wdata_i,
   output logic [31:0] st_wdata_o,
   output logic [3:0]  st_be_o,
   input  logic [1:0]  ld_off_i,
   input  logic [1:0]  ld_size_i,
   input  logic        ld_unsigned_i,
   input  logic [31:0] ld_rdata_i,
   output logic [31:0] ld_data_o
);

   logic [31:0] ld_shift;

   // Store: replicate the low byte/half across all lanes, enable only the target lanes
   always_comb begin
      st_wdata_o = st_wdata_i;
      st_be_o    = 4'b1111;
      case (eff_size(st_size_i))
         LWHB_B: begin
            st_wdata_o = {4{st_wdata_i[7:0]}};
            st_be_o    = 4'b0001 << st_off_i;
         end
         LWHB_H: begin
            st_wdata_o = {2{st_wdata_i[15:0]}};
            st_be_o    = 4'b0011 << {st_off_i[1], 1'b0};
         end
         default: ;
      endcase
   end

   // Load: move the addressed lane to bit 0, then extend
   always_comb begin
      ld_shift  = ld_rdata_i >> {ld_off_i, 3'b000};
      ld_data_o = ld_shift;
      case (eff_size(ld_size_i))
         LWHB_B: ld_data_o = ld_unsigned_i ? {24'h0, ld_shift[7:0]}
                                           : {{24{ld_shift[7]}}, ld_shift[7:0]};
         LWHB_H: ld_data_o = ld_unsigned_i ? {16'h0, ld_shift[15:0]}
                                           : {{16{ld_shift[15]}}, ld_shift[15:0]};
         default: ;
      endcase
   end

endmodule

// File: rtl/xgriscv_mem_arbiter.sv
// Shares one single-ported memory between instruction fetch (i_*) and
// load/store (d_*) ports. One outstanding transaction; data has priority
// except when the fetch port has been starved for STARVE_LIMIT data grants.
//   i_req/i_addr -> i_gnt, i_rvalid/i_rdata
//   d_req/d_we/d_addr/d_wdata/d_swhb/d_lwhb/d_lunsigned -> d_gnt, d_rvalid/d_rdata, d_misalign
//   mem_req/we/addr/be/wdata <-> mem_gnt, mem_rvalid/mem_rdata
module xgriscv_mem_arbiter
   import xgriscv_mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_req,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   output logic                  i_gnt,
   output logic                  i_rvalid,
   output logic [DATA_WIDTH-1:0] i_rdata,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [DATA_WIDTH-1:0] d_wdata,
   input  logic [1:0]            d_swhb,
   input  logic [1:0]            d_lwhb,
   input  logic                  d_lunsigned,
   output logic                  d_gnt,
   output logic                  d_rvalid,
   output logic [DATA_WIDTH-1:0] d_rdata,
   output logic                  d_misalign,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [3:0]            mem_be,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic                  mem_gnt,
   input  logic                  mem_rvalid,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   localparam int unsigned CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);

   arb_state_e            state_q, state_d;
   logic [CW-1:0]         starve_q, starve_d;
   dctx_t                 ctx_q, ctx_d;
   logic                  i_rvalid_q, i_rvalid_d, d_rvalid_q, d_rvalid_d;
   logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;

   logic                  force_i, pick_d, pick_i, d_mis;
   logic [1:0]            d_size;
   logic [31:0]           st_wdata, ld_data;
   logic [3:0]            st_be;

   logic                  i_gnt_c, d_gnt_c, d_mis_c, mem_req_c, mem_we_c;
   logic [ADDR_WIDTH-1:0] mem_addr_c;
   logic [3:0]            mem_be_c;
   logic [DATA_WIDTH-1:0] mem_wdata_c;

   // Combinational arbitration, only meaningful in IDLE
   assign force_i = (STARVE_LIMIT != 0) && (starve_q == CW'(STARVE_LIMIT));
   assign pick_d  = d_req && (!i_req || !force_i);
   assign pick_i  = i_req && !pick_d;
   assign d_size  = d_we ? d_swhb : d_lwhb;
   assign d_mis   = is_misaligned(d_size, d_addr[1:0]);

   xgriscv_lane_align u_lane_align (
      .st_off_i      (d_addr[1:0]),
      .st_size_i     (d_swhb),
      .st_wdata_i    (d_wdata),
      .st_wdata_o    (st_wdata),
      .st_be_o       (st_be),
      .ld_off_i      (ctx_q.off),
      .ld_size_i     (ctx_q.lwhb),
      .ld_unsigned_i (ctx_q.lunsigned),
      .ld_rdata_i    (mem_rdata),
      .ld_data_o     (ld_data)
   );

   // State and datapath registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         starve_q   <= '0;
         ctx_q      <= '0;
         i_rvalid_q <= 1'b0;
         i_rdata_q  <= '0;
         d_rvalid_q <= 1'b0;
         d_rdata_q  <= '0;
      end else begin
         state_q    <= state_d;
         starve_q   <= starve_d;
         ctx_q      <= ctx_d;
         i_rvalid_q <= i_rvalid_d;
         i_rdata_q  <= i_rdata_d;
         d_rvalid_q <= d_rvalid_d;
         d_rdata_q  <= d_rdata_d;
      end
   end

   // Next-state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_d && !d_mis && mem_gnt) state_d = ST_WAIT_D;
            else if (pick_i && mem_gnt)      state_d = ST_WAIT_I;
         end
         ST_WAIT_I: if (mem_rvalid) state_d = ST_IDLE;
         ST_WAIT_D: if (mem_rvalid) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Outputs: the IDLE winner drives the memory port; misaligned data is rejected locally
   always_comb begin
      i_gnt_c     = 1'b0;
      d_gnt_c     = 1'b0;
      d_mis_c     = 1'b0;
      mem_req_c   = 1'b0;
      mem_we_c    = 1'b0;
      mem_addr_c  = '0;
      mem_be_c    = 4'b0000;
      mem_wdata_c = '0;
      if (state_q == ST_IDLE) begin
         if (pick_d) begin
            if (d_mis) begin
               d_gnt_c = 1'b1;
               d_mis_c = 1'b1;
            end else begin
               mem_req_c   = 1'b1;
               mem_we_c    = d_we;
               mem_addr_c  = d_addr & WORD_MASK;
               mem_be_c    = d_we ? st_be : 4'b1111;
               mem_wdata_c = d_we ? st_wdata : '0;
               d_gnt_c     = mem_gnt;
            end
         end else if (pick_i) begin
            mem_req_c  = 1'b1;
            mem_addr_c = i_addr & WORD_MASK;
            mem_be_c   = 4'b1111;
            i_gnt_c    = mem_gnt;
         end
      end
   end

   // Starvation counter, grant context capture and response forwarding
   always_comb begin
      starve_d   = starve_q;
      ctx_d      = ctx_q;
      i_rvalid_d = 1'b0;
      i_rdata_d  = '0;
      d_rvalid_d = 1'b0;
      d_rdata_d  = '0;
      if (!i_req || i_gnt_c)
         starve_d = '0;
      else if (d_gnt_c && (starve_q != CW'(STARVE_LIMIT)))
         starve_d = starve_q + CW'(1);
      if (d_gnt_c && !d_mis_c)
         ctx_d = '{off: d_addr[1:0], lwhb: d_lwhb, lunsigned: d_lunsigned, we: d_we};
      if ((state_q == ST_WAIT_I) && mem_rvalid) begin
         i_rvalid_d = 1'b1;
         i_rdata_d  = mem_rdata;
      end
      if ((state_q == ST_WAIT_D) && mem_rvalid) begin
         d_rvalid_d = 1'b1;
         d_rdata_d  = ctx_q.we ? '0 : ld_data;
      end
   end

   // Hold every output at 0 while reset is asserted
   assign i_gnt      = i_gnt_c & reset;
   assign d_gnt      = d_gnt_c & reset;
   assign d_misalign = d_mis_c & reset;
   assign mem_req    = mem_req_c & reset;
   assign mem_we     = mem_we_c & reset;
   assign mem_addr   = reset ? mem_addr_c : '0;
   assign mem_be     = reset ? mem_be_c : 4'b0000;
   assign mem_wdata  = reset ? mem_wdata_c : '0;
   assign i_rvalid   = i_rvalid_q;
   assign i_rdata    = i_rdata_q;
   assign d_rvalid   = d_rvalid_q;
   assign d_rdata    = d_rdata_q;

endmodule
